// File: rtl/fifo_pair_wr_sched_pkg.sv
// Shared types for the paired-write FIFO scheduler: FSM states, requester select,
// and the timeout counter sizing used when FIFO_PAIR_TMO_EN is defined.
package fifo_pair_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HALF = 2'd1,
      PAIR = 2'd2
   } state_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_sel_e;

   localparam int TIMEOUT_CYC_DEF = 16;

   function automatic int tmo_cnt_w(input int cyc);
      return (cyc < 2) ? 1 : $clog2(cyc);
   endfunction

   localparam int TMO_CNT_W = tmo_cnt_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/fifo_pair_wr_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves after a contested
// grant that was actually taken (advance high).
module rr_arb2
   import fifo_pair_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   req_sel_e ptr_q, ptr_d;

   always_comb begin
      gnt   = req;
      ptr_d = ptr_q;
      if (req == 2'b11) begin
         gnt = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
         if (advance) begin
            ptr_d = (ptr_q == REQ_A) ? REQ_B : REQ_A;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= REQ_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fifo_pair_wr_sched.sv
// Write-side scheduler: arbitrates A/B words, packs them into pairs for the FIFO.
// Build option FIFO_PAIR_TMO_EN adds an auto-flush of a lone word after TIMEOUT_CYC idle cycles.
module fifo_pair_wr_sched
   import fifo_pair_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] PAD_WORD    = '0,
   parameter int                    TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    a_valid,
   input  logic [DATA_WIDTH-1:0]   a_data,
   output logic                    a_ready,
   input  logic                    b_valid,
   input  logic [DATA_WIDTH-1:0]   b_data,
   output logic                    b_ready,
   input  logic                    flush,
   input  logic                    fifo_full,
   input  logic                    fifo_one_left,
   input  logic                    fifo_rd,
   output logic                    fifo_wr,
   output logic [2*DATA_WIDTH-1:0] fifo_w_data,
   output logic                    held,
   output logic                    tmo_flush
);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   lo_q, lo_d;
   logic [DATA_WIDTH-1:0]   hi_q, hi_d;
   logic [1:0]              gnt;
   logic                    can_wr;
   logic                    accept_en;
   logic                    accept;
   logic                    tmo_fire;
   logic [DATA_WIDTH-1:0]   acc_word;

   assign can_wr    = (~fifo_full & ~fifo_one_left) | (fifo_one_left & fifo_rd);
   assign accept_en = (state_q != PAIR) | can_wr;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({b_valid, a_valid}),
      .advance (accept_en),
      .gnt     (gnt)
   );

   // Gated by reset so the requesters see no handshake while reset is asserted.
   assign a_ready  = gnt[0] & accept_en & reset;
   assign b_ready  = gnt[1] & accept_en & reset;
   assign accept   = a_ready | b_ready;
   assign acc_word = a_ready ? a_data : b_data;

   assign fifo_wr     = (state_q == PAIR);
   assign fifo_w_data = {hi_q, lo_q};
   assign held        = (state_q == HALF);
   assign tmo_flush   = tmo_fire;

`ifdef FIFO_PAIR_TMO_EN
   localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             half_idle;

   assign half_idle = (state_q == HALF) & ~accept & ~flush;
   assign tmo_fire  = half_idle & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if ((state_d == HALF) && (state_q != HALF)) begin
         cnt_d = '0;
      end else if (half_idle && !tmo_fire) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign tmo_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               lo_d    = acc_word;
               state_d = HALF;
            end
         end
         HALF: begin
            if (accept) begin
               hi_d    = acc_word;
               state_d = PAIR;
            end else if (flush || tmo_fire) begin
               hi_d    = PAD_WORD;
               state_d = PAIR;
            end
         end
         PAIR: begin
            // The pair leaves this cycle; a concurrent word starts the next pair.
            if (can_wr) begin
               if (accept) begin
                  lo_d    = acc_word;
                  state_d = HALF;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

endmodule

// File: tb/tb_fifo_pair_wr_sched.sv
// Self-checking bench for fifo_pair_wr_sched: queue-level pairing model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_pair_wr_sched;

   localparam int        DW  = 8;
   localparam logic [7:0] PAD = 8'h00;
   localparam int        TMO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic          a_ready, b_ready;
   logic          flush = 1'b0, fifo_full = 1'b0, fifo_one_left = 1'b0, fifo_rd = 1'b0;
   logic          fifo_wr, held, tmo_flush;
   logic [2*DW-1:0] fifo_w_data;

   fifo_pair_wr_sched #(.DATA_WIDTH(DW), .PAD_WORD(PAD), .TIMEOUT_CYC(TMO)) dut (
      .clk           (clk),
      .reset         (reset),
      .a_valid       (a_valid),
      .a_data        (a_data),
      .a_ready       (a_ready),
      .b_valid       (b_valid),
      .b_data        (b_data),
      .b_ready       (b_ready),
      .flush         (flush),
      .fifo_full     (fifo_full),
      .fifo_one_left (fifo_one_left),
      .fifo_rd       (fifo_rd),
      .fifo_wr       (fifo_wr),
      .fifo_w_data   (fifo_w_data),
      .held          (held),
      .tmo_flush     (tmo_flush)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: words waiting to be paired, and a pair waiting for FIFO space.
   logic [7:0]  m_lo;
   int          m_nbuf;
   bit          m_pv;
   logic [15:0] m_pair;
   bit          m_prio_b;
   int          m_idle;

   logic [15:0] dut_wr_q[$];
   int          tmo_seen;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_reset();
      m_lo = '0; m_nbuf = 0; m_pv = 0; m_pair = '0; m_prio_b = 0; m_idle = 0;
   endtask

   task automatic step(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd,
                       input bit fl, input bit full, input bit one, input bit rd,
                       output bit acc_a, output bit acc_b);
      bit can, space, ga, gb, ea, eb, e_wr, e_held, e_tmo, acc;
      logic [7:0] w;
      @(negedge clk);
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
      flush = fl; fifo_full = full; fifo_one_left = one; fifo_rd = rd;
      #1;
      can   = (!full && !one) || (one && rd);
      space = !m_pv || can;
      if (av && bv) begin
         ga = !m_prio_b; gb = m_prio_b;
      end else begin
         ga = av; gb = bv;
      end
      ea     = ga && space;
      eb     = gb && space;
      acc    = ea || eb;
      e_wr   = m_pv;
      e_held = !m_pv && (m_nbuf == 1);
`ifdef FIFO_PAIR_TMO_EN
      e_tmo  = e_held && !acc && !fl && (m_idle == TMO - 1);
`else
      e_tmo  = 1'b0;
`endif
      chk("fifo_wr", 32'(fifo_wr), 32'(e_wr));
      chk("held", 32'(held), 32'(e_held));
      chk("a_ready", 32'(a_ready), 32'(ea));
      chk("b_ready", 32'(b_ready), 32'(eb));
      chk("tmo_flush", 32'(tmo_flush), 32'(e_tmo));
      if (e_wr) chk("fifo_w_data", 32'(fifo_w_data), 32'(m_pair));
      if (tmo_flush) tmo_seen++;
      if (fifo_wr && can) begin
         dut_wr_q.push_back(fifo_w_data);
         $display("write %h", fifo_w_data);
      end
      acc_a = a_ready;
      acc_b = b_ready;
      // Advance the model by one cycle.
      w = ea ? ad : bd;
      if (m_pv && can) m_pv = 0;
      if (acc) begin
         if (m_nbuf == 1) begin
            m_pair = {w, m_lo}; m_pv = 1; m_nbuf = 0;
         end else begin
            m_lo = w; m_nbuf = 1; m_idle = 0;
         end
      end else if (e_held && (fl || e_tmo)) begin
         m_pair = {PAD, m_lo}; m_pv = 1; m_nbuf = 0;
      end else if (e_held) begin
         m_idle++;
      end
      if (av && bv && acc) m_prio_b = !m_prio_b;
   endtask

   task automatic idle_step();
      bit xa, xb;
      step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, xa, xb);
   endtask

   task automatic send_a(input logic [7:0] d);
      bit xa, xb;
      step(1, d, 0, 8'h00, 0, 0, 0, 0, xa, xb);
      chk("send_a accepted", 32'(xa), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit xa, xb;
      logic [7:0] ai, bi;
      model_reset();
      tmo_seen = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset fifo_wr", 32'(fifo_wr), 32'd0);
      chk("reset held", 32'(held), 32'd0);
      chk("reset data", 32'(fifo_w_data), 32'd0);
      chk("reset tmo", 32'(tmo_flush), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Pairing: 11 then 22 -> 2211.
      dut_wr_q.delete();
      send_a(8'h11);
      send_a(8'h22);
      idle_step();
      chk("pair count", 32'(dut_wr_q.size()), 32'd1);
      if (dut_wr_q.size() >= 1) chk("pair 2211", 32'(dut_wr_q[0]), 32'h2211);
      idle_step();

      // Contention: alternating grants starting with A.
      dut_wr_q.delete();
      ai = 8'hA0; bi = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         step(1, ai, 1, bi, 0, 0, 0, 0, xa, xb);
         if (i == 0) chk("first grant A", 32'(xa), 32'd1);
         if (xa) ai = ai + 8'd1;
         if (xb) bi = bi + 8'd1;
      end
      idle_step();
      chk("contention count", 32'(dut_wr_q.size()), 32'd2);
      if (dut_wr_q.size() >= 2) begin
         chk("contention pair0", 32'(dut_wr_q[0]), 32'hB0A0);
         chk("contention pair1", 32'(dut_wr_q[1]), 32'hB1A1);
      end

      // Backpressure: full holds the pair, one_left+rd releases it with a concurrent A word.
      dut_wr_q.delete();
      send_a(8'h33);
      send_a(8'h44);
      for (int i = 0; i < 3; i++) begin
         step(1, 8'h55, 0, 8'h00, 0, 1, 0, 0, xa, xb);
         chk("bp ready low", 32'(xa), 32'd0);
         chk("bp data stable", 32'(fifo_w_data), 32'h4433);
      end
      step(1, 8'h55, 0, 8'h00, 0, 0, 1, 1, xa, xb);
      chk("bp release accept", 32'(xa), 32'd1);
      idle_step();
      chk("bp held after", 32'(held), 32'd1);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, xa, xb);
      idle_step();
      chk("bp count", 32'(dut_wr_q.size()), 32'd2);
      if (dut_wr_q.size() >= 2) begin
         chk("bp pair0", 32'(dut_wr_q[0]), 32'h4433);
         chk("bp pair1", 32'(dut_wr_q[1]), 32'h0055);
      end

      // Flush: pad a lone word, then flush coinciding with a B word.
      dut_wr_q.delete();
      send_a(8'h5C);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, xa, xb);
      idle_step();
      send_a(8'h5C);
      step(0, 8'h00, 1, 8'h77, 1, 0, 0, 0, xa, xb);
      idle_step();
      chk("flush count", 32'(dut_wr_q.size()), 32'd2);
      if (dut_wr_q.size() >= 2) begin
         chk("flush pad", 32'(dut_wr_q[0]), 32'h005C);
         chk("flush with B", 32'(dut_wr_q[1]), 32'h775C);
      end
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, xa, xb);
      chk("flush idle no effect", 32'(held), 32'd0);

      // Lone word with no traffic.
      dut_wr_q.delete();
      tmo_seen = 0;
      send_a(8'h99);
      for (int i = 0; i < TMO + 4; i++) idle_step();
`ifdef FIFO_PAIR_TMO_EN
      chk("tmo pulses", 32'(tmo_seen), 32'd1);
      chk("tmo held", 32'(held), 32'd0);
      if (dut_wr_q.size() >= 1) chk("tmo pair", 32'(dut_wr_q[0]), 32'h0099);
      else chk("tmo pair count", 32'(dut_wr_q.size()), 32'd1);
`else
      chk("tmo pulses", 32'(tmo_seen), 32'd0);
      chk("tmo held", 32'(held), 32'd1);
      step(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, xa, xb);
      idle_step();
`endif

      // Reset while a pair is held back by a full FIFO.
      send_a(8'h01);
      send_a(8'h02);
      step(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, xa, xb);
      @(negedge clk);
      a_valid = 1'b1; b_valid = 1'b1; fifo_full = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst fifo_wr", 32'(fifo_wr), 32'd0);
      chk("rst held", 32'(held), 32'd0);
      chk("rst a_ready", 32'(a_ready), 32'd0);
      chk("rst b_ready", 32'(b_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      model_reset();
      idle_step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit rav, rbv, rfl, rfull, rone, rrd;
         rav   = ($urandom_range(0, 99) < 55);
         rbv   = ($urandom_range(0, 99) < 45);
         rfl   = ($urandom_range(0, 99) < 8);
         rfull = ($urandom_range(0, 99) < 20);
         rone  = !rfull && ($urandom_range(0, 99) < 25);
         rrd   = ($urandom_range(0, 99) < 50);
         step(rav, 8'($urandom), rbv, 8'($urandom), rfl, rfull, rone, rrd, xa, xb);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
